// File: rtl/sym_frame_sched.sv
// sym_frame_sched
//   Builds framed 2-bit line symbols for the downstream level encoder and
//   shares it between two byte-stream requesters. A frame is a preamble,
//   FRAME_BYTES data bytes (MSB pair first, four symbols per byte), then an
//   idle gap. Ownership is round-robin and is held for the whole frame.
//
// Handshake: a byte moves on a rising edge where reqN_valid and reqN_ready
//   are both high. reqN_ready depends only on internal state and counters,
//   never on reqN_valid, so a requester may hold valid high indefinitely.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req0_valid/data/ready    requester 0 byte stream
//   req1_valid/data/ready    requester 1 byte stream
//   sym_out                  symbol to the level encoder (registered)
//   sym_en                   sym_out carries a preamble or data symbol
//   grant                    one-hot owner of the current frame, 00 when idle
//   busy                     scheduler is not idle
//   frame_done               pulse on the last data symbol of a frame
module sym_frame_sched #(
    parameter int         PREAMBLE_LEN = 4,
    parameter logic [1:0] PREAMBLE_SYM = 2'b10,
    parameter logic [1:0] IDLE_SYM     = 2'b00,
    parameter int         FRAME_BYTES  = 2,
    parameter int         GAP_LEN      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [1:0] sym_out,
    output logic       sym_en,
    output logic [1:0] grant,
    output logic       busy,
    output logic       frame_done
);

    localparam int            BW       = $clog2(FRAME_BYTES + 1);
    localparam logic [3:0]    PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_LEN - 1);
    localparam logic [BW-1:0] FB_ALL   = BW'(FRAME_BYTES);
    localparam logic [BW-1:0] BYTE_ONE = BW'(1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;             // preamble / gap cycle counter
    logic [1:0]    sym_cnt, sym_cnt_nxt;     // index of the symbol on sym_out
    logic [BW-1:0] byte_cnt, byte_cnt_nxt;   // bytes accepted this frame
    logic [5:0]    shreg, shreg_nxt;         // remaining symbols of the byte
    logic          last_grant, last_grant_nxt;
    logic [1:0]    sym_out_nxt, grant_nxt;
    logic          sym_en_nxt, busy_nxt, frame_done_nxt;

    logic          rdy, take, sel_valid, pick1;
    logic [7:0]    sel_data;

    // In DATA, sym_en low means the scheduler is stalled waiting for a byte,
    // so ready stays up until the owner delivers it.
    assign rdy = ((state == PRE) && (cnt == PRE_LAST)) ||
                 ((state == DATA) && (!sym_en || (sym_cnt == 2'd3)) &&
                  (byte_cnt < FB_ALL));

    assign req0_ready = rdy & grant[0];
    assign req1_ready = rdy & grant[1];

    assign sel_valid = grant[1] ? req1_valid : req0_valid;
    assign sel_data  = grant[1] ? req1_data  : req0_data;
    assign take      = rdy & sel_valid;

    // On a tie the requester that did not own the previous frame wins.
    assign pick1 = req1_valid && (!req0_valid || !last_grant);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sym_cnt_nxt    = sym_cnt;
        byte_cnt_nxt   = byte_cnt;
        shreg_nxt      = shreg;
        last_grant_nxt = last_grant;
        grant_nxt      = grant;
        busy_nxt       = busy;
        sym_out_nxt    = IDLE_SYM;
        sym_en_nxt     = 1'b0;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nxt      = PRE;
                    grant_nxt      = pick1 ? 2'b10 : 2'b01;
                    last_grant_nxt = pick1;
                    busy_nxt       = 1'b1;
                    sym_out_nxt    = PREAMBLE_SYM;
                    sym_en_nxt     = 1'b1;
                    cnt_nxt        = 4'd0;
                    sym_cnt_nxt    = 2'd0;
                    byte_cnt_nxt   = '0;
                end
            end
            PRE: begin
                if (cnt != PRE_LAST) begin
                    cnt_nxt     = cnt + 4'd1;
                    sym_out_nxt = PREAMBLE_SYM;
                    sym_en_nxt  = 1'b1;
                end else begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (!rdy) begin
                    if (sym_cnt != 2'd3) begin
                        sym_cnt_nxt    = sym_cnt + 2'd1;
                        sym_out_nxt    = shreg[5:4];
                        shreg_nxt      = {shreg[3:0], 2'b00};
                        sym_en_nxt     = 1'b1;
                        frame_done_nxt = (sym_cnt == 2'd2) && (byte_cnt == FB_ALL);
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            GAP: begin
                if (cnt != GAP_LAST) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A byte accepted at this edge starts emitting immediately; a ready
        // cycle without valid leaves the idle defaults (underrun).
        if (take) begin
            state_nxt    = DATA;
            shreg_nxt    = sel_data[5:0];
            sym_out_nxt  = sel_data[7:6];
            sym_en_nxt   = 1'b1;
            sym_cnt_nxt  = 2'd0;
            byte_cnt_nxt = byte_cnt + BYTE_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            sym_cnt    <= 2'd0;
            byte_cnt   <= '0;
            shreg      <= 6'd0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            busy       <= 1'b0;
            sym_out    <= IDLE_SYM;
            sym_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sym_cnt    <= sym_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            shreg      <= shreg_nxt;
            last_grant <= last_grant_nxt;
            grant      <= grant_nxt;
            busy       <= busy_nxt;
            sym_out    <= sym_out_nxt;
            sym_en     <= sym_en_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_sym_frame_sched.sv
// tb_sym_frame_sched
//   Two instances: one with default parameters and one with a 1-symbol
//   preamble and 1-byte frames; inputs are shared, outputs selected by
//   use_small. A frame-level model turns (requests, bytes, stall lengths)
//   into a per-cycle expected trace and a per-cycle input script.
//   Expected vector layout: {rdy1, rdy0, frame_done, busy, grant, sym_en, sym_out}.
module tb_sym_frame_sched;

    localparam logic [1:0] PRE_SYM  = 2'b10;
    localparam logic [1:0] IDLE_SYM = 2'b00;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;

    logic       d_r0, d_r1, d_en, d_busy, d_fd;
    logic [1:0] d_sym, d_grant;
    logic       s_r0, s_r1, s_en, s_busy, s_fd;
    logic [1:0] s_sym, s_grant;

    logic       use_small;
    logic [8:0] obs;

    logic [8:0]  exp_q[$];
    logic [17:0] drv_q[$];

    logic [7:0] fr_b [4];
    int         fr_s [4];
    int         last_owner;
    int         n_vec;
    int         n_err;
    string      cur_test;

    sym_frame_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(d_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(d_r1),
        .sym_out(d_sym), .sym_en(d_en), .grant(d_grant), .busy(d_busy),
        .frame_done(d_fd)
    );

    sym_frame_sched #(.PREAMBLE_LEN(1), .FRAME_BYTES(1)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
        .sym_out(s_sym), .sym_en(s_en), .grant(s_grant), .busy(s_busy),
        .frame_done(s_fd)
    );

    assign obs = use_small ? {s_r1, s_r0, s_fd, s_busy, s_grant, s_en, s_sym}
                           : {d_r1, d_r0, d_fd, d_busy, d_grant, d_en, d_sym};

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] pk(input int own, input logic [1:0] g,
                                      input logic bsy, input logic fd,
                                      input logic en, input logic [1:0] sym,
                                      input logic rdy);
        logic [1:0] r;
        r = 2'b00;
        if (rdy) r[own] = 1'b1;
        return {r, fd, bsy, g, en, sym};
    endfunction

    function automatic logic [17:0] dp(input int own, input logic vo,
                                       input logic [7:0] dat, input logic vx,
                                       input logic [7:0] dx);
        if (own == 0) return {vx, dx, vo, dat};
        return {vo, dat, vx, dx};
    endfunction

    function automatic logic ov(input int of, input int c);
        return (of >= 0) && (c >= of);
    endfunction

    // Frame model: owner chosen by round-robin over the request mask, then
    // preamble, bytes with optional stalls when each byte is due, then gap.
    task automatic add_frame(input logic [1:0] mask, input int pl, input int fb,
                             input int gl, input int other_from);
        int         own, c;
        logic [1:0] g, cur, sym;
        logic [7:0] dx, bb, nd;
        logic       vo;
        own = (mask == 2'b11) ? 1 - last_owner : (mask[1] ? 1 : 0);
        last_owner = own;
        g  = (own == 1) ? 2'b10 : 2'b01;
        dx = 8'($urandom);
        exp_q.push_back(pk(0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE_SYM, 1'b0));
        drv_q.push_back(dp(own, 1'b1, fr_b[0], mask[1 - own], dx));
        c = 1;
        for (int p = 1; p < pl; p++) begin
            exp_q.push_back(pk(own, g, 1'b1, 1'b0, 1'b1, PRE_SYM, 1'b0));
            drv_q.push_back(dp(own, 1'b1, fr_b[0], ov(other_from, c), dx));
            c++;
        end
        cur = PRE_SYM;
        for (int i = 0; i < fb; i++) begin
            for (int s = 0; s <= fr_s[i]; s++) begin
                exp_q.push_back(pk(own, g, 1'b1, 1'b0, (s == 0),
                                   (s == 0) ? cur : IDLE_SYM, 1'b1));
                drv_q.push_back(dp(own, (s == fr_s[i]), fr_b[i], ov(other_from, c), dx));
                c++;
            end
            bb = fr_b[i];
            for (int k = 0; k < 4; k++) begin
                sym = 2'(bb >> (6 - 2 * k));
                if (k == 3 && i < fb - 1) begin
                    cur = sym;
                end else begin
                    exp_q.push_back(pk(own, g, 1'b1, (i == fb - 1) && (k == 3),
                                       1'b1, sym, 1'b0));
                    vo = (i < fb - 1);
                    nd = vo ? fr_b[i + 1] : 8'h00;
                    drv_q.push_back(dp(own, vo, nd, ov(other_from, c), dx));
                    c++;
                end
            end
        end
        for (int q = 0; q < gl; q++) begin
            exp_q.push_back(pk(own, g, 1'b1, 1'b0, 1'b0, IDLE_SYM, 1'b0));
            drv_q.push_back(dp(own, 1'b0, 8'h00, ov(other_from, c), dx));
            c++;
        end
    endtask

    task automatic idle_tail();
        exp_q.push_back(pk(0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE_SYM, 1'b0));
        drv_q.push_back(18'd0);
    endtask

    // driver: each cycle check outputs at the falling edge, then drive inputs
    task automatic play(input int n);
        logic [8:0]  e;
        logic [17:0] d;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL %s vec %0d: got %b expected %b (rdy1 rdy0 fd busy grant en sym)",
                         cur_test, n_vec, obs, e);
            end
            {req1_valid, req1_data, req0_valid, req0_data} = d;
        end
    endtask

    task automatic play_all();
        play(exp_q.size());
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 4; i++) fr_s[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {req1_valid, req1_data, req0_valid, req0_data} = 18'd0;
        @(negedge clk);
        rst = 1'b0;
        last_owner = 1;
        exp_q.delete();
        drv_q.delete();
        clear_stalls();
    endtask

    task automatic test_reset();
        logic [8:0] e;
        cur_test = "reset";
        rst = 1'b1;
        {req1_valid, req1_data, req0_valid, req0_data} = 18'd0;
        repeat (2) @(negedge clk);
        e = pk(0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE_SYM, 1'b0);
        for (int u = 0; u < 2; u++) begin
            use_small = u[0];
            #1;
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset inst%0d: got %b expected %b", u, obs, e);
            end
        end
        use_small = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_owner = 1;
    endtask

    task automatic test_single_frame();
        do_reset();
        cur_test = "single_frame";
        fr_b[0] = 8'hB4;
        fr_b[1] = 8'h1E;
        add_frame(2'b01, 4, 2, 2, -1);
        idle_tail();
        play_all();
    endtask

    task automatic test_underrun();
        do_reset();
        cur_test = "underrun";
        fr_b[0] = 8'hB4;
        fr_b[1] = 8'h1E;
        fr_s[1] = 3;
        add_frame(2'b01, 4, 2, 2, -1);
        idle_tail();
        play_all();
    endtask

    task automatic test_round_robin();
        do_reset();
        cur_test = "round_robin";
        for (int f = 0; f < 4; f++) begin
            fr_b[0] = 8'($urandom);
            fr_b[1] = 8'($urandom);
            add_frame(2'b11, 4, 2, 2, 0);
        end
        idle_tail();
        play_all();
    endtask

    task automatic test_wait_other();
        do_reset();
        cur_test = "wait_other";
        fr_b[0] = 8'($urandom);
        fr_b[1] = 8'($urandom);
        add_frame(2'b01, 4, 2, 2, 3);
        fr_b[0] = 8'($urandom);
        fr_b[1] = 8'($urandom);
        add_frame(2'b10, 4, 2, 2, -1);
        idle_tail();
        play_all();
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] e;
        do_reset();
        cur_test = "reset_mid_frame";
        fr_b[0] = 8'($urandom);
        fr_b[1] = 8'($urandom);
        add_frame(2'b01, 4, 2, 2, -1);
        play(7);
        #2;
        rst = 1'b1;
        {req1_valid, req1_data, req0_valid, req0_data} = 18'd0;
        #1;
        e = pk(0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE_SYM, 1'b0);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_mid_frame async: got %b expected %b", obs, e);
        end
        @(negedge clk);
        rst = 1'b0;
        last_owner = 1;
        exp_q.delete();
        drv_q.delete();
        fr_b[0] = 8'($urandom);
        fr_b[1] = 8'($urandom);
        add_frame(2'b10, 4, 2, 2, -1);
        idle_tail();
        play_all();
    endtask

    task automatic test_small_frame();
        do_reset();
        cur_test = "small_frame";
        use_small = 1'b1;
        fr_b[0] = 8'($urandom);
        add_frame(2'b01, 1, 1, 2, -1);
        fr_b[0] = 8'($urandom);
        fr_s[0] = 2;
        add_frame(2'b10, 1, 1, 2, -1);
        idle_tail();
        play_all();
        use_small = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] m;
        do_reset();
        cur_test = "random";
        for (int f = 0; f < 8; f++) begin
            m = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                fr_b[i] = 8'($urandom);
                fr_s[i] = $urandom_range(0, 3);
            end
            add_frame(m, 4, 2, 2, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1);
        end
        idle_tail();
        play_all();
    endtask

    initial begin
        use_small  = 1'b0;
        rst        = 1'b1;
        {req1_valid, req1_data, req0_valid, req0_data} = 18'd0;
        n_vec      = 0;
        n_err      = 0;
        last_owner = 1;
        cur_test   = "init";
        clear_stalls();
        test_reset();
        test_single_frame();
        test_underrun();
        test_round_robin();
        test_wait_other();
        test_reset_mid_frame();
        test_small_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sym_frame_sched.md
Name: sym_frame_sched

Overview:
- Frames and schedules 2-bit line symbols for the level encoder, which maps each 2-bit symbol to a 3-bit drive level every clock.
- Shares that single encoder between two byte-stream requesters using round-robin arbitration, with grant held for a whole frame.
- Each frame is a preamble, then FRAME_BYTES data bytes serialized MSB-pair first, then an idle gap.
- Sits directly upstream of the level encoder.

Parameters:
PREAMBLE_LEN, 4, preamble symbols per frame; legal range 1..15
PREAMBLE_SYM, 2'b10, symbol emitted during the preamble
IDLE_SYM, 2'b00, symbol driven when no valid symbol is present
FRAME_BYTES, 2, data bytes per frame; legal range 1..255
GAP_LEN, 2, idle cycles after each frame; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req0_valid  input  1  requester 0 has a byte on req0_data
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle (when valid is also high)
req1_valid  input  1  requester 1 has a byte on req1_data
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle (when valid is also high)
sym_out  output  2  symbol to the level encoder
sym_en  output  1  sym_out carries a preamble or data symbol
grant  output  2  one-hot owner of the current frame; 00 when idle
busy  output  1  state is not IDLE
frame_done  output  1  one-cycle pulse on the last data symbol of a frame

Behaviour:
- Reset is asynchronous, active-high, and acts immediately, including mid-frame.
  - Outputs on reset: sym_out=IDLE_SYM, sym_en=0, grant=00, busy=0, frame_done=0, both ready=0.
  - Internal state on reset: state IDLE, last_grant=1 (so req0 wins the first tie).
  - A partial frame is discarded; requesters must resend the whole frame.
- FSM states: IDLE, PRE, DATA, GAP. sym_out, sym_en, grant, busy and frame_done are registered. readyN is combinational from state and counters only, never from validN.
- IDLE:
  - Sample the valids. If exactly one is high, grant that requester. If both are high, grant the one that is not last_grant.
  - At the next edge: state becomes PRE, grant and last_grant update, sym_out=PREAMBLE_SYM, sym_en=1.
  - A request that appears during PRE, DATA or GAP waits; it is evaluated only in IDLE.
- PRE:
  - Runs for PREAMBLE_LEN cycles, emitting PREAMBLE_SYM.
  - The granted ready is high during the last PRE cycle.
- DATA: the byte buffer is loaded when the granted ready and valid are both high.
  - Each byte emits 4 symbols, one per cycle: bits[7:6], [5:4], [3:2], [1:0].
  - Ready is high in the cycle that emits a byte's bits[1:0], provided fewer than FRAME_BYTES bytes have been accepted. This gives gapless back-to-back bytes.
  - Underrun (ready high, valid low): the cycle(s) after show sym_out=IDLE_SYM, sym_en=0.
    - Ready stays high until the byte is accepted.
    - Symbols resume in the cycle after acceptance. The frame is not aborted.
  - The ungranted requester's ready is always 0.
  - After the last symbol of byte FRAME_BYTES-1: frame_done pulses together with that symbol, and the state becomes GAP.
- GAP:
  - Runs for GAP_LEN cycles with sym_out=IDLE_SYM, sym_en=0, grant held, busy=1.
  - Then returns to IDLE, where grant=00 and busy=0. The minimum spacing between frames is GAP_LEN+1 cycles.
- Timing without underrun, with grant sampled in cycle T:
  - Preamble occupies T+1..T+PREAMBLE_LEN.
  - Data occupies the next 4*FRAME_BYTES cycles.
- Counters: a symbol counter 0..3 and a byte counter of width ceil(log2(FRAME_BYTES+1)). Both clear on entry to PRE and never wrap within a frame.

Test Plan:
1. Reset asserted mid-DATA for 1 cycle -> same cycle: sym_en=0, grant=00, busy=0, both ready=0. After release: IDLE, and the next req1-only request is granted with req1.
2. Defaults, req0 only, bytes 0xB4 then 0x1E, valid always high -> sym_out 10,10,10,10, 10,11,01,00, 00,01,11,10 with sym_en=1. frame_done coincides with the final 10. Then 2 cycles of sym_en=0 and grant=01 before busy drops.
3. req0 and req1 both valid in IDLE after reset -> grant=01. After that frame, both still valid -> grant=10. Then req0 again -> strict alternation over 4 frames.
4. req0 valid drops for 3 cycles when the second byte is due -> 3 cycles of sym_out=00, sym_en=0 with req0_ready held high. Byte 0x1E then emits 00,01,11,10. frame_done still pulses exactly once.
5. req1 raises valid during a req0 frame -> req1_ready stays 0 throughout. req1 is granted only in the IDLE cycle after GAP.
6. PREAMBLE_LEN=1, FRAME_BYTES=1 -> exactly 1 preamble symbol. req0_ready is high in the grant+1 cycle. 4 data symbols follow, then GAP.
